// File: rtl/led_shift_driver_if.sv
// Frame-engine bundle: start/status handshake, frame RAM read port and serial LED pins.
// The master side is the engine; the slave side is the controller plus frame RAM and pins.
interface led_shift_driver_if #(
  parameter int c_aw   = 1,
  parameter int c_bits = 16
);
  logic              i_start;
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [c_aw-1:0]   o_rd_addr;
  logic [c_bits-1:0] i_rd_data;
  logic              o_clk;
  logic              o_dai;
  logic              o_lat;

  modport master (
    input  i_start, i_rd_data,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_clk, o_dai, o_lat
  );

  modport slave (
    output i_start, i_rd_data,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_clk, o_dai, o_lat
  );
endinterface

// File: rtl/led_shift_driver.sv
// Serial frame engine for daisy-chained LED drivers: fetches N words (highest address first),
// shifts each MSB first on SCLK/SDI, then pulses LAT and reports done.
module led_shift_driver #(
  parameter int c_chips    = 1,
  parameter int c_channels = 16,
  parameter int c_bits     = 16,
  parameter int c_div      = 2,
  parameter int c_lat_len  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  led_shift_driver_if.master bus
);

  localparam int N    = c_chips * c_channels;
  localparam int c_aw = (N > 1) ? $clog2(N) : 1;
  localparam int BW   = (c_bits > 1) ? $clog2(c_bits) : 1;
  localparam int CMAX = (c_div > c_lat_len) ? c_div : c_lat_len;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [c_aw-1:0] WORD_FIRST = c_aw'(N - 1);
  localparam logic [BW-1:0]   BIT_FIRST  = BW'(c_bits - 1);
  localparam logic [CW-1:0]   DIV_LAST   = CW'(c_div - 1);
  localparam logic [CW-1:0]   LAT_LAST   = CW'(c_lat_len - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_LO, S_HI, S_LATCH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [c_aw-1:0]   word_q, word_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [c_bits-1:0] sh_q, sh_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      word_q  <= WORD_FIRST;
      bit_q   <= BIT_FIRST;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // cnt_q times both the SCLK half-periods and the LAT pulse; it is always zero on entry to either.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: begin
        word_d = WORD_FIRST;
        if (bus.i_start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sh_d    = bus.i_rd_data;
        bit_d   = BIT_FIRST;
        cnt_d   = '0;
        state_d = S_LO;
      end
      S_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HI: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (bit_q != '0) begin
            sh_d    = sh_q << 1;
            bit_d   = bit_q - 1'b1;
            state_d = S_LO;
          end else if (word_q != '0) begin
            word_d  = word_q - 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy    = 1'b0;
    bus.o_done    = 1'b0;
    bus.o_rd_en   = 1'b0;
    bus.o_rd_addr = '0;
    bus.o_clk     = 1'b0;
    bus.o_dai     = 1'b0;
    bus.o_lat     = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.o_busy    = 1'b1;
        bus.o_rd_en   = 1'b1;
        bus.o_rd_addr = word_q;
      end
      S_LOAD: bus.o_busy = 1'b1;
      S_LO: begin
        bus.o_busy = 1'b1;
        bus.o_dai  = sh_q[c_bits-1];
      end
      S_HI: begin
        bus.o_busy = 1'b1;
        bus.o_clk  = 1'b1;
        bus.o_dai  = sh_q[c_bits-1];
      end
      S_LATCH: begin
        bus.o_busy = 1'b1;
        bus.o_lat  = 1'b1;
      end
      S_DONE:  bus.o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: three instances (short frame, slow SCLK, 3-chip chain)
// checked against a hand-written cycle table and directed corner-case sequences.
module tb_led_shift_driver;
  logic clk;
  logic rst;

  led_shift_driver_if #(.c_aw(1), .c_bits(4))  a_if ();
  led_shift_driver_if #(.c_aw(1), .c_bits(4))  b_if ();
  led_shift_driver_if #(.c_aw(6), .c_bits(16)) c_if ();

  led_shift_driver #(.c_chips(1), .c_channels(2), .c_bits(4), .c_div(1), .c_lat_len(2))
    u_a (.i_clk(clk), .i_rst(rst), .bus(a_if.master));
  led_shift_driver #(.c_chips(1), .c_channels(2), .c_bits(4), .c_div(3), .c_lat_len(2))
    u_b (.i_clk(clk), .i_rst(rst), .bus(b_if.master));
  led_shift_driver #(.c_chips(3), .c_channels(16), .c_bits(16), .c_div(2), .c_lat_len(2))
    u_c (.i_clk(clk), .i_rst(rst), .bus(c_if.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame RAMs: one-cycle read latency, garbage on cycles that were not read
  logic [3:0]  ram_a [2];
  logic [15:0] ram_c [48];
  always @(posedge clk) begin
    a_if.i_rd_data <= a_if.o_rd_en ? ram_a[a_if.o_rd_addr] : 4'($urandom);
    b_if.i_rd_data <= b_if.o_rd_en ? ram_a[b_if.o_rd_addr] : 4'($urandom);
    c_if.i_rd_data <= c_if.o_rd_en ? ram_c[c_if.o_rd_addr] : 16'($urandom);
  end

  logic [2:0] m_clk, m_dai, m_lat, m_rd, m_done;
  assign m_clk  = {c_if.o_clk,   b_if.o_clk,   a_if.o_clk};
  assign m_dai  = {c_if.o_dai,   b_if.o_dai,   a_if.o_dai};
  assign m_lat  = {c_if.o_lat,   b_if.o_lat,   a_if.o_lat};
  assign m_rd   = {c_if.o_rd_en, b_if.o_rd_en, a_if.o_rd_en};
  assign m_done = {c_if.o_done,  b_if.o_done,  a_if.o_done};

  // Pin monitor: captured bits at SCLK rises, event counts, protocol violations
  int          rises [3] = '{0, 0, 0};
  int          rds   [3] = '{0, 0, 0};
  int          lats  [3] = '{0, 0, 0};
  int          dones [3] = '{0, 0, 0};
  int          viol  [3] = '{0, 0, 0};
  int          hirun [3] = '{0, 0, 0};
  logic [1023:0] bits [3];
  logic [2:0]  p_clk = 3'b000;
  logic [2:0]  p_dai = 3'b000;
  int          rt [16];
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (m_clk[k] && !p_clk[k]) begin
        bits[k] = {bits[k][1022:0], m_dai[k]};
        if (k == 1 && rises[1] < 16) rt[rises[1]] = cyc;
        rises[k]++;
        if (m_dai[k] !== p_dai[k]) viol[k]++;
      end
      if (m_clk[k]) begin
        hirun[k]++;
      end else begin
        if (p_clk[k] && hirun[k] != ((k == 0) ? 1 : (k == 1) ? 3 : 2)) viol[k]++;
        hirun[k] = 0;
      end
      if (m_clk[k] && m_lat[k]) viol[k]++;
      if (m_rd[k])   rds[k]++;
      if (m_lat[k])  lats[k]++;
      if (m_done[k]) dones[k]++;
    end
    p_clk = m_clk;
    p_dai = m_dai;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Returns the number of negedges until o_done is seen, or -1 past the budget
  task automatic wait_done(input int k, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_done[k] && n < maxc);
    if (!m_done[k]) n = -1;
  endtask

  function automatic logic [6:0] a_out();
    return {a_if.o_busy, a_if.o_done, a_if.o_rd_en, a_if.o_rd_addr,
            a_if.o_clk, a_if.o_dai, a_if.o_lat};
  endfunction

  // {busy, done, rd_en, rd_addr, clk, dai, lat} per cycle of one frame on instance A
  typedef struct {
    logic       start;
    logic [6:0] exp;
  } vec_t;
  vec_t tab [25];

  int n, n2, s0, s1, s2, s3;
  logic [767:0] exp_c;

  initial begin
    tab[0]  = '{1'b1, 7'b0000000};
    tab[1]  = '{1'b0, 7'b1011000};
    tab[2]  = '{1'b0, 7'b1000000};
    tab[3]  = '{1'b0, 7'b1000010};
    tab[4]  = '{1'b0, 7'b1000110};
    tab[5]  = '{1'b0, 7'b1000000};
    tab[6]  = '{1'b0, 7'b1000100};
    tab[7]  = '{1'b0, 7'b1000010};
    tab[8]  = '{1'b0, 7'b1000110};
    tab[9]  = '{1'b0, 7'b1000000};
    tab[10] = '{1'b0, 7'b1000100};
    tab[11] = '{1'b0, 7'b1010000};
    tab[12] = '{1'b0, 7'b1000000};
    tab[13] = '{1'b0, 7'b1000000};
    tab[14] = '{1'b0, 7'b1000100};
    tab[15] = '{1'b0, 7'b1000010};
    tab[16] = '{1'b0, 7'b1000110};
    tab[17] = '{1'b0, 7'b1000000};
    tab[18] = '{1'b0, 7'b1000100};
    tab[19] = '{1'b0, 7'b1000010};
    tab[20] = '{1'b0, 7'b1000110};
    tab[21] = '{1'b0, 7'b1000001};
    tab[22] = '{1'b0, 7'b1000001};
    tab[23] = '{1'b0, 7'b0100000};
    tab[24] = '{1'b0, 7'b0000000};

    ram_a[1] = 4'hA;
    ram_a[0] = 4'h5;
    for (int a = 0; a < 48; a++) ram_c[a] = 16'(a);
    exp_c = '0;
    for (int a = 47; a >= 0; a--) exp_c = {exp_c[751:0], 16'(a)};

    a_if.i_start = 1'b0;
    b_if.i_start = 1'b0;
    c_if.i_start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a", a_out(), 7'b0);
    chk("rst_b", {b_if.o_busy, b_if.o_done, b_if.o_rd_en, b_if.o_rd_addr,
                  b_if.o_clk, b_if.o_dai, b_if.o_lat}, 0);
    chk("rst_c", {c_if.o_busy, c_if.o_done, c_if.o_rd_en, c_if.o_rd_addr,
                  c_if.o_clk, c_if.o_dai, c_if.o_lat}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T1/T2: cycle-exact frame; RAM word 1 overwritten after it was loaded
    s0 = rds[0]; s1 = lats[0]; s2 = dones[0]; s3 = rises[0];
    for (int i = 0; i < 25; i++) begin
      a_if.i_start = tab[i].start;
      if (i == 5) ram_a[1] = 4'h0;
      @(negedge clk);
      chk($sformatf("t1_cyc%0d", i), a_out(), tab[i].exp);
      @(posedge clk); #1;
    end
    ram_a[1] = 4'hA;
    chk("t2_rd_pulses", rds[0] - s0, 2);
    chk("t1_lat_cycles", lats[0] - s1, 2);
    chk("t1_done_pulses", dones[0] - s2, 1);
    chk("t1_rises", rises[0] - s3, 8);
    chk("t1_stream", bits[0][7:0], 8'hA5);

    // T4: start mid-shift and during DONE is dropped
    s2 = dones[0];
    a_if.i_start = 1'b1; @(posedge clk); #1; a_if.i_start = 1'b0;
    repeat (5) @(posedge clk); #1;
    a_if.i_start = 1'b1; @(posedge clk); #1; a_if.i_start = 1'b0;
    wait_done(0, 100, n);
    chk("t4_done_seen", n > 0, 1);
    a_if.i_start = 1'b1; @(posedge clk); #1; a_if.i_start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t4_done_pulses", dones[0] - s2, 1);
    chk("t4_idle_after", a_if.o_busy, 0);
    @(posedge clk); #1;

    // Held start: back-to-back frames, DONE then one IDLE cycle between them
    s2 = dones[0];
    a_if.i_start = 1'b1; @(posedge clk); #1;
    wait_done(0, 100, n);
    wait_done(0, 100, n2);
    @(posedge clk); #1; a_if.i_start = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("held_latency", n, 23);
    chk("held_interval", n2, 24);
    chk("held_done_pulses", dones[0] - s2, 2);

    // T5: reset in SHIFT_HI of the first word, then a clean frame
    s1 = lats[0];
    a_if.i_start = 1'b1; @(posedge clk); #1; a_if.i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_in_hi", a_if.o_clk, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_out", a_out(), 7'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("t5_no_latch", lats[0] - s1, 0);
    s3 = rises[0];
    a_if.i_start = 1'b1; @(posedge clk); #1; a_if.i_start = 1'b0;
    wait_done(0, 100, n);
    @(posedge clk); #1;
    chk("t5_latency", n, 23);
    chk("t5_rises", rises[0] - s3, 8);
    chk("t5_stream", bits[0][7:0], 8'hA5);
    chk("a_violations", viol[0], 0);

    // T3: divide-by-3 SCLK
    s3 = rises[1];
    b_if.i_start = 1'b1; @(posedge clk); #1; b_if.i_start = 1'b0;
    wait_done(1, 200, n);
    @(posedge clk); #1;
    chk("t3_latency", n, 55);
    chk("t3_rises", rises[1] - s3, 8);
    chk("t3_stream", bits[1][7:0], 8'hA5);
    chk("t3_violations", viol[1], 0);
    for (int j = 1; j < 8; j++)
      chk($sformatf("t3_period%0d", j), rt[j] - rt[j-1], (j == 4) ? 8 : 6);

    // T6: three 16-channel chips, 16-bit words
    s0 = rds[2]; s1 = lats[2]; s3 = rises[2];
    c_if.i_start = 1'b1; @(posedge clk); #1; c_if.i_start = 1'b0;
    wait_done(2, 4000, n);
    @(posedge clk); #1;
    chk("t6_latency", n, 3171);
    chk("t6_rises", rises[2] - s3, 768);
    chk("t6_reads", rds[2] - s0, 48);
    chk("t6_lat_cycles", lats[2] - s1, 2);
    chk("t6_stream", {256'b0, bits[2][767:0]}, {256'b0, exp_c});
    chk("t6_violations", viol[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
